// File: rtl/ip_msx_cartbus.sv
// rtl/ip_msx_cartbus.sv - MSX cartridge I/O bus responder bridging qualified bus accesses to the VDP req/ack port
module ip_msx_cartbus #(
  parameter int unsigned DEBOUNCE   = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [7:0]  DUMMY_READ = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       n_ce,
  input  logic       n_twr,
  input  logic       n_trd,
  input  logic [1:0] ta,
  input  logic [7:0] td_in,
  output logic [7:0] td_out,
  output logic       tdir,
  output logic       twait,
  output logic       req,
  output logic       wr,
  output logic [1:0] address,
  output logic [7:0] wdata,
  input  logic       ack,
  input  logic [7:0] rdata
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {ARMWAIT, IDLE, BUSY, RELEASE} state_t;

  state_t     state, state_n;
  logic [2:0] strb_q1, strb_s;
  logic [1:0] ta_q1, ta_s;
  logic [7:0] td_q1, td_s;
  logic       ce_s, wr_s, rd_s;
  logic       acc_rd, acc_wr, acc, strobe_on;

  logic [3:0] qual, qual_n, qual_inc;
  logic       last_wr, last_wr_n;
  logic [7:0] tmo, tmo_n, tmo_inc;
  logic       req_n, wr_n, tdir_n, twait_n;
  logic [1:0] address_n;
  logic [7:0] wdata_n, td_out_n;

  // Strobe synchronisers reset to "active" so ARMWAIT waits for a genuinely idle bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      strb_q1 <= 3'b000;
      strb_s  <= 3'b000;
      ta_q1   <= '0;
      ta_s    <= '0;
      td_q1   <= '0;
      td_s    <= '0;
    end else begin
      strb_q1 <= {n_ce, n_twr, n_trd};
      strb_s  <= strb_q1;
      ta_q1   <= ta;
      ta_s    <= ta_q1;
      td_q1   <= td_in;
      td_s    <= td_q1;
    end
  end

  assign ce_s      = strb_s[2];
  assign wr_s      = strb_s[1];
  assign rd_s      = strb_s[0];
  assign acc_rd    = !ce_s && !rd_s && wr_s;
  assign acc_wr    = !ce_s && !wr_s && rd_s;
  assign acc       = acc_rd || acc_wr;
  assign strobe_on = !ce_s && (wr ? !wr_s : !rd_s);
  assign qual_inc  = qual + 4'd1;
  assign tmo_inc   = (tmo == 8'hFF) ? tmo : tmo + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARMWAIT;
      qual    <= '0;
      last_wr <= 1'b0;
      tmo     <= '0;
      req     <= 1'b0;
      wr      <= 1'b0;
      address <= '0;
      wdata   <= '0;
      td_out  <= '0;
      tdir    <= 1'b0;
      twait   <= 1'b0;
    end else begin
      state   <= state_n;
      qual    <= qual_n;
      last_wr <= last_wr_n;
      tmo     <= tmo_n;
      req     <= req_n;
      wr      <= wr_n;
      address <= address_n;
      wdata   <= wdata_n;
      td_out  <= td_out_n;
      tdir    <= tdir_n;
      twait   <= twait_n;
    end
  end

  always_comb begin
    state_n   = state;
    qual_n    = qual;
    last_wr_n = last_wr;
    tmo_n     = tmo;
    req_n     = req;
    wr_n      = wr;
    address_n = address;
    wdata_n   = wdata;
    td_out_n  = td_out;
    tdir_n    = tdir;
    twait_n   = twait;
    case (state)
      ARMWAIT: begin
        qual_n = '0;
        if (ce_s && wr_s && rd_s) state_n = IDLE;
      end
      IDLE: begin
        last_wr_n = acc_wr;
        if (acc && (qual == '0 || last_wr == acc_wr)) begin
          if (qual_inc == DEB) begin
            qual_n    = '0;
            address_n = ta_s;
            wr_n      = acc_wr;
            wdata_n   = td_s;
            req_n     = 1'b1;
            twait_n   = 1'b1;
            tmo_n     = '0;
            state_n   = BUSY;
          end else begin
            qual_n = qual_inc;
          end
        end else begin
          qual_n = '0;
        end
      end
      BUSY: begin
        tmo_n = tmo_inc;
        // ack has priority over a simultaneous timeout.
        if (ack) begin
          req_n   = 1'b0;
          state_n = RELEASE;
          if (!wr) begin
            td_out_n = rdata;
            tdir_n   = strobe_on;
          end
        end else if (tmo_inc == TMO) begin
          req_n   = 1'b0;
          state_n = RELEASE;
          if (!wr) begin
            td_out_n = DUMMY_READ;
            tdir_n   = strobe_on;
          end
        end
      end
      RELEASE: begin
        twait_n = 1'b0;
        if (!strobe_on) begin
          tdir_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = ARMWAIT;
    endcase
  end

endmodule

// File: doc/ip_msx_cartbus.md
Name: ip_msx_cartbus

Overview:
- Responder for the MSX cartridge I/O bus.
- Synchronises the MSX strobes n_ce, n_twr and n_trd, the address ta and the data td into the clk domain, then turns each qualified access into one req/ack transaction toward the VDP clone's REQ/ACK/WRT/ADR/DBO/DBI port.
- It is the other end of the interface that the debugger drives today, so the VDP can be driven from the real MSX bus.
- It also drives tdir, td and twait back to the cartridge connector.

Parameters:
- DEBOUNCE, 2: consecutive synchronised cycles an access condition must hold before it is accepted (1..15).
- TIMEOUT, 255: clk cycles to wait for ack before aborting (8-bit counter).
- DUMMY_READ, 8'hFF: value returned on a read that timed out.

Ports:
- clk  in  1  system clock (87.75 MHz).
- reset  in  1  synchronous, active-high reset.
- n_ce  in  1  cartridge I/O chip enable, asynchronous, active low.
- n_twr  in  1  write strobe, asynchronous, active low.
- n_trd  in  1  read strobe, asynchronous, active low.
- ta  in  2  port address, asynchronous.
- td_in  in  8  data from the MSX, asynchronous.
- td_out  out  8  read data toward the MSX.
- tdir  out  1  1 = FPGA drives td (output-enable and level-shifter direction).
- twait  out  1  1 = hold the MSX in a wait state.
- req  out  1  transaction request to the VDP.
- wr  out  1  1 = write, 0 = read; valid while req=1.
- address  out  2  latched ta; valid while req=1.
- wdata  out  8  latched td_in; valid while req=1.
- ack  in  1  one-cycle completion pulse from the VDP.
- rdata  in  8  VDP read data; valid in the ack cycle.

Behaviour:
- Synchronisers:
  - n_ce, n_twr, n_trd, ta and td_in each pass through a 2-FF synchroniser.
  - All decoding uses the second stage only.
  - acc_rd = !ce_s & !rd_s & wr_s; acc_wr = !ce_s & !wr_s & rd_s.
  - Both strobes low at once is illegal and is treated as no access.
- Reset:
  - state = ARMWAIT; req = wr = tdir = twait = 0; address = 0; wdata = 0; td_out = 0; all counters cleared.
  - Reset asserted mid-transaction aborts immediately; no ack is expected afterwards and any later ack is ignored.
- States:
  - ARMWAIT: go to IDLE once ce_s = rd_s = wr_s = 1. This prevents a half access from being accepted after reset.
  - IDLE: a 4-bit qual counter increments while acc_rd or acc_wr is true and the type is unchanged. It clears otherwise, including when the type changes.
  - When qual reaches DEBOUNCE:
    - latch address = ta_s, wr = acc_wr, wdata = td_s;
    - set req = 1 and twait = 1; clear the timeout counter;
    - go to BUSY.
    - Latency from a synchronised access to req is DEBOUNCE cycles, 2 + DEBOUNCE cycles from the pins.
  - BUSY: req, wr, address and wdata are held stable until ack is seen. On ack:
    - req = 0 in the next cycle;
    - for a read, td_out = rdata and tdir = 1 in the next cycle;
    - go to RELEASE.
  - BUSY timeout: if the timeout counter reaches TIMEOUT with no ack:
    - req = 0;
    - for a read, td_out = DUMMY_READ and tdir = 1;
    - go to RELEASE.
  - RELEASE: twait falls 1 cycle after entry, so for reads td_out is stable for ≥1 cycle before the wait is released. Stay until the access terminates (ce_s = 1, or the active strobe's sync = 1), then:
    - tdir = 0; td_out keeps its value;
    - go to IDLE.
    - No new access is accepted until the bus has been seen idle. Exactly one transaction per MSX strobe.
- ack outside BUSY is ignored.
- ack and timeout in the same cycle: ack wins and rdata is used.
- Strobe released while in BUSY (the MSX ignored twait): the transaction still completes toward the VDP. tdir is not asserted for a read whose strobe is already gone; the FSM passes through RELEASE for 1 cycle, then returns to IDLE.
- Timeout counter: 8 bits, saturating; it does not wrap.
- wr stays driven after req falls, and its value is don't-care while req=0.

Test Plan:
- Reset with n_ce = n_twr = 0 held → no req. Release the strobes → ARMWAIT to IDLE. The next write is accepted normally.
- Write, ta = 2'b01, td = 8'h8A, VDP acks 3 cycles after req → exactly one req with wr = 1, address = 1, wdata = 8'h8A. twait = 1 from req until 1 cycle after ack. tdir stays 0 throughout.
- Read, ta = 2'b00, ack with rdata = 8'h5C → td_out = 8'h5C and tdir = 1 the cycle after ack. twait drops one cycle later. tdir = 0 two synchroniser cycles after n_trd rises.
- Read with ack withheld → req drops after 255 cycles. td_out = 8'hFF, tdir = 1, twait released.
- A 1-cycle glitch on n_trd (DEBOUNCE = 2), and a case with n_twr and n_trd both low → no req. A long strobe held 500 cycles → exactly one transaction.
- Reset asserted while in BUSY → req, twait and tdir are 0 the next cycle. A late ack is ignored and produces no td_out change.
